// File: rtl/emu_run_ctrl.sv
// Host-side run/pause controller: counts target cycles, single-steps,
// and pauses on breakpoint, masked trap triggers or host request.
module emu_run_ctrl #(
  parameter int unsigned CNT_WIDTH    = 64,
  parameter int unsigned NUM_TRIG     = 4,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic                  host_clk,
  input  logic                  host_rst_n,
  input  logic                  tick,
  input  logic                  do_pause,
  input  logic                  do_resume,
  input  logic [NUM_TRIG-1:0]   trig,
  input  logic                  trig_en_write,
  input  logic [NUM_TRIG-1:0]   trig_en_wdata,
  input  logic                  count_write,
  input  logic [CNT_WIDTH-1:0]  count_wdata,
  input  logic                  step_write,
  input  logic [CNT_WIDTH-1:0]  step_wdata,
  input  logic                  bp_write,
  input  logic [CNT_WIDTH-1:0]  bp_wdata,
  input  logic                  bp_en_wdata,
  output logic                  run_mode,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [CNT_WIDTH-1:0]  step,
  output logic [NUM_TRIG+2:0]   reason,
  output logic                  step_trig,
  output logic                  pause_evt
);

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [CNT_WIDTH-1:0]   step_q, step_d;
  logic [CNT_WIDTH-1:0]   bp_val_q, bp_val_d;
  logic                   bp_en_q, bp_en_d;
  logic [NUM_TRIG-1:0]    trig_en_q, trig_en_d;
  logic [NUM_TRIG+2:0]    reason_q, reason_d;
  logic                   pend_q, pend_d;
  logic                   pause_evt_q, pause_evt_d;

  logic                   adv;
  logic                   bp_hit;
  logic [NUM_TRIG-1:0]    trg;
  logic                   pause_go;

  assign adv    = (state_q == RUN) && tick;
  assign trg    = trig & trig_en_q & {NUM_TRIG{adv}};
  assign bp_hit = bp_en_q && adv && ((count_q + ONE) == bp_val_q);

  always_comb begin
    count_d = count_q;
    if (count_write) begin
      count_d = count_wdata;
    end else if (adv) begin
      count_d = count_q + ONE;
    end
  end

  always_comb begin
    step_d = step_q;
    if (step_write) begin
      step_d = step_wdata;
    end else if ((step_q != '0) && adv) begin
      step_d = step_q - ONE;
    end
  end

  assign step_trig = (step_q != '0) && (step_d == '0);

  always_comb begin
    bp_val_d  = bp_val_q;
    bp_en_d   = bp_en_q;
    trig_en_d = trig_en_q;
    if (bp_write) begin
      bp_val_d = bp_wdata;
      bp_en_d  = bp_en_wdata;
    end
    if (trig_en_write) begin
      trig_en_d = trig_en_wdata;
    end
  end

  // A pause only ever lands on a counted tick, so the final cycle is kept.
  assign pause_go = adv &&
    (pend_q | do_pause | step_trig | bp_hit | (|trg));

  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    pend_d      = pend_q;
    pause_evt_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (pause_go) begin
          state_d     = PAUSED;
          reason_d    = {trg, bp_hit, step_trig,
                         pend_q | do_pause};
          pend_d      = 1'b0;
          pause_evt_d = 1'b1;
        end else if (do_pause) begin
          pend_d = 1'b1;
        end
      end
      PAUSED: begin
        if (do_resume) begin
          state_d  = RUN;
          reason_d = '0;
          pend_d   = 1'b0;
        end
      end
      default: state_d = PAUSED;
    endcase
  end

  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      state_q     <= RUN_ON_RESET ? RUN : PAUSED;
      count_q     <= '0;
      step_q      <= '0;
      bp_val_q    <= '0;
      bp_en_q     <= 1'b0;
      trig_en_q   <= '1;
      reason_q    <= '0;
      pend_q      <= 1'b0;
      pause_evt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      step_q      <= step_d;
      bp_val_q    <= bp_val_d;
      bp_en_q     <= bp_en_d;
      trig_en_q   <= trig_en_d;
      reason_q    <= reason_d;
      pend_q      <= pend_d;
      pause_evt_q <= pause_evt_d;
    end
  end

  assign run_mode  = (state_q == RUN);
  assign count     = count_q;
  assign step      = step_q;
  assign reason    = reason_q;
  assign pause_evt = pause_evt_q;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Directed bench for emu_run_ctrl: run, step, breakpoint,
// trigger, host pause/resume, counter wrap and async reset.
module tb_emu_run_ctrl;

  localparam int CW = 64;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick, do_pause, do_resume;
  logic [NT-1:0] trig, trig_en_wdata;
  logic          trig_en_write, count_write;
  logic          step_write, bp_write, bp_en_wdata;
  logic [CW-1:0] count_wdata, step_wdata, bp_wdata;
  logic          run_mode, step_trig, pause_evt;
  logic [CW-1:0] count, step;
  logic [NT+2:0] reason;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  emu_run_ctrl #(
    .CNT_WIDTH(CW), .NUM_TRIG(NT), .RUN_ON_RESET(1'b1)
  ) dut (
    .host_clk(clk), .host_rst_n(rst_n), .tick(tick),
    .do_pause(do_pause), .do_resume(do_resume), .trig(trig),
    .trig_en_write(trig_en_write), .trig_en_wdata(trig_en_wdata),
    .count_write(count_write), .count_wdata(count_wdata),
    .step_write(step_write), .step_wdata(step_wdata),
    .bp_write(bp_write), .bp_wdata(bp_wdata),
    .bp_en_wdata(bp_en_wdata), .run_mode(run_mode),
    .count(count), .step(step), .reason(reason),
    .step_trig(step_trig), .pause_evt(pause_evt)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic resume();
    do_resume = 1'b1;
    cyc();
    do_resume = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 0; do_pause = 0; do_resume = 0;
    trig = '0; trig_en_write = 0; trig_en_wdata = '0;
    count_write = 0; count_wdata = '0; step_write = 0;
    step_wdata = '0; bp_write = 0; bp_wdata = '0;
    bp_en_wdata = 0;
    #12;
    check("rst_run", run_mode, 1);
    check("rst_count", count, 0);
    check("rst_reason", reason, 0);
    check("rst_evt", pause_evt, 0);
    rst_n = 1'b1;
    cyc();

    ticks(10);
    check("t1_run", run_mode, 1);
    check("t1_count", count, 10);
    check("t1_reason", reason, 0);

    count_write = 1; count_wdata = 0;
    step_write = 1; step_wdata = 5;
    cyc();
    count_write = 0; step_write = 0;
    ticks(4);
    check("t2_step", step, 1);
    check("t2_run4", run_mode, 1);
    tick = 1'b1;
    #1;
    check("t2_strig", step_trig, 1);
    cyc();
    tick = 1'b0;
    check("t2_run", run_mode, 0);
    check("t2_count", count, 5);
    check("t2_reason", reason, 7'b0000010);
    check("t2_evt1", pause_evt, 1);
    cyc();
    check("t2_evt0", pause_evt, 0);
    ticks(3);
    check("t2_hold", count, 5);

    count_write = 1; count_wdata = 0;
    bp_write = 1; bp_wdata = 100; bp_en_wdata = 1;
    cyc();
    count_write = 0; bp_write = 0;
    resume();
    check("t3_resumed", run_mode, 1);
    check("t3_rclr", reason, 0);
    ticks(100);
    check("t3_run", run_mode, 0);
    check("t3_count", count, 100);
    check("t3_reason", reason, 7'b0000100);
    resume();
    ticks(50);
    check("t3_count2", count, 150);
    check("t3_run2", run_mode, 1);
    bp_write = 1; bp_wdata = 0; bp_en_wdata = 0;
    cyc();
    bp_write = 0;

    trig_en_write = 1; trig_en_wdata = 4'b0010;
    count_write = 1; count_wdata = 0;
    cyc();
    trig_en_write = 0; count_write = 0;
    trig = 4'b0001;
    ticks(6);
    check("t4_run6", run_mode, 1);
    check("t4_count6", count, 6);
    trig = 4'b0011;
    ticks(1);
    trig = 4'b0000;
    check("t4_run", run_mode, 0);
    check("t4_count", count, 7);
    check("t4_reason", reason, 7'b0010000);
    resume();

    do_pause = 1'b1;
    cyc();
    do_pause = 1'b0;
    cyc();
    check("t5_still", run_mode, 1);
    ticks(1);
    check("t5_run", run_mode, 0);
    check("t5_reason", reason, 7'b0000001);
    do_pause = 1'b1; do_resume = 1'b1;
    cyc();
    do_pause = 1'b0; do_resume = 1'b0;
    check("t5_both", run_mode, 1);
    check("t5_rclr", reason, 0);
    ticks(1);
    check("t5_nopend", run_mode, 1);

    count_write = 1; count_wdata = '1;
    bp_write = 1; bp_wdata = 0; bp_en_wdata = 1;
    cyc();
    count_write = 0; bp_write = 0;
    ticks(1);
    check("t6_wrap", count, 0);
    check("t6_run", run_mode, 0);
    check("t6_reason", reason, 7'b0000100);
    resume();

    step_write = 1; step_wdata = 3;
    cyc();
    step_write = 0;
    ticks(1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_step", step, 0);
    check("ar_count", count, 0);
    check("ar_run", run_mode, 1);
    check("ar_evt", pause_evt, 0);
    rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
